// File: rtl/score_ctrl.sv
// -----------------------------------------------------------------------------
// score_ctrl
//
// Score controller for the 8x8 Flappy Bird game. Counts points as a 3-digit BCD
// score and runs the round protocol IDLE -> PLAY -> OVER. It also drives the
// three 7-segment displays, alternating between the live score and the session
// high score while the game is over.
//
// Build option:
//   SCORE_CTRL_HIGH_SCORE_EN - when defined, the design adds the best-score
//   register, the compare on game over, the phase timer and the score/best
//   display alternation. When it is not defined, new_best and show_best are
//   tied low, and OVER shows the frozen score continuously.
//
// Parameters:
//   SHOW_CYCLES - cycles each of score/best stays on the displays in OVER (>= 2)
//
// Ports:
//   clock      in   system clock, all logic on posedge
//   reset      in   asynchronous, active-high reset
//   score_in   in   point level; one point per rising transition
//   game_over  in   rising transition ends the round
//   start      in   rising transition starts/restarts a round
//   hex2/1/0   out  hundreds/tens/ones digit, active-low {g,f,e,d,c,b,a}
//   playing    out  high in PLAY
//   show_best  out  high while the displays show the best score
//   new_best   out  the last round set a new best
//   overflow   out  sticky: score wrapped past 999 this round
// -----------------------------------------------------------------------------
module score_ctrl #(
    parameter int SHOW_CYCLES = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       score_in,
    input  logic       game_over,
    input  logic       start,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       playing,
    output logic       show_best,
    output logic       new_best,
    output logic       overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        score_in_q, game_over_q, start_q;
    logic [11:0] score_q, score_d;      // {hundreds, tens, ones} BCD
    logic        overflow_q, overflow_d;
    logic [6:0]  hex_q [3];
    logic [6:0]  hex_d [3];
    logic [11:0] disp_value;

    // Input event detection
    logic pt_ev, go_ev, st_ev;
    assign pt_ev = score_in  & ~score_in_q;
    assign go_ev = game_over & ~game_over_q;
    assign st_ev = start     & ~start_q;

    // BCD increment with carry ripple across digits, wrapping 999 -> 000
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            if (v[7:4] == 4'd9) begin
                r[7:4] = 4'd0;
                if (v[11:8] == 4'd9) r[11:8] = 4'd0;
                else                 r[11:8] = v[11:8] + 4'd1;
            end else begin
                r[7:4] = v[7:4] + 4'd1;
            end
        end else begin
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [11:0] score_inc;
    logic        score_wrap;
    assign score_inc  = bcd_inc(score_q);
    assign score_wrap = (score_q == 12'h999);

`ifdef SCORE_CTRL_HIGH_SCORE_EN
    localparam int TW = $clog2(SHOW_CYCLES);

    logic [11:0]   best_q, best_d;
    logic          new_best_q, new_best_d;
    logic          show_best_q, show_best_d;
    logic [TW-1:0] timer_q, timer_d;
`endif

    // Next-state / datapath logic
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        overflow_d = overflow_q;
`ifdef SCORE_CTRL_HIGH_SCORE_EN
        best_d      = best_q;
        new_best_d  = new_best_q;
        show_best_d = show_best_q;
        timer_d     = timer_q;
`endif
        // start has the highest priority in every state; a restart also
        // suppresses any game_over compare in the same cycle.
        if (st_ev) begin
            state_d    = ST_PLAY;
            score_d    = 12'h000;
            overflow_d = 1'b0;
`ifdef SCORE_CTRL_HIGH_SCORE_EN
            show_best_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // points are ignored until a round starts
                end
                ST_PLAY: begin
                    if (pt_ev) begin
                        score_d = score_inc;
                        if (score_wrap) overflow_d = 1'b1;
                    end
                    if (go_ev) begin
                        state_d = ST_OVER;
`ifdef SCORE_CTRL_HIGH_SCORE_EN
                        // Compare uses the score including a same-cycle point.
                        // Valid BCD orders the same as plain binary.
                        show_best_d = 1'b0;
                        timer_d     = '0;
                        if (score_d > best_q) begin
                            best_d     = score_d;
                            new_best_d = 1'b1;
                        end else begin
                            new_best_d = 1'b0;
                        end
`endif
                    end
                end
                ST_OVER: begin
`ifdef SCORE_CTRL_HIGH_SCORE_EN
                    if (timer_q == TW'(SHOW_CYCLES - 1)) begin
                        timer_d     = '0;
                        show_best_d = ~show_best_q;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef SCORE_CTRL_HIGH_SCORE_EN
    assign disp_value = show_best_q ? best_q : score_q;
`else
    assign disp_value = score_q;
`endif

    // One segment decoder per displayed digit
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            assign hex_d[gi] = seg7(disp_value[gi*4 +: 4]);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            score_in_q  <= 1'b0;
            game_over_q <= 1'b0;
            start_q     <= 1'b0;
            score_q     <= 12'h000;
            overflow_q  <= 1'b0;
            for (int i = 0; i < 3; i++) hex_q[i] <= 7'b1000000;
        end else begin
            state_q     <= state_d;
            score_in_q  <= score_in;
            game_over_q <= game_over;
            start_q     <= start;
            score_q     <= score_d;
            overflow_q  <= overflow_d;
            for (int i = 0; i < 3; i++) hex_q[i] <= hex_d[i];
        end
    end

`ifdef SCORE_CTRL_HIGH_SCORE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            best_q      <= 12'h000;
            new_best_q  <= 1'b0;
            show_best_q <= 1'b0;
            timer_q     <= '0;
        end else begin
            best_q      <= best_d;
            new_best_q  <= new_best_d;
            show_best_q <= show_best_d;
            timer_q     <= timer_d;
        end
    end

    assign new_best  = new_best_q;
    assign show_best = show_best_q;
`else
    // Without the high-score logic the display period has no use.
    logic unused_cfg;
    assign unused_cfg = (SHOW_CYCLES >= 2);

    assign new_best  = 1'b0;
    assign show_best = 1'b0;
`endif

    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign playing  = (state_q == ST_PLAY);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_score_ctrl.sv
// -----------------------------------------------------------------------------
// tb_score_ctrl
//
// Self-checking bench for score_ctrl: a directed vector table, hand-written
// corner-case sequences and randomized stimulus. Every output is compared on
// every clock against a behavioural model (integer score, cycle count in OVER).
// -----------------------------------------------------------------------------
module tb_score_ctrl;

    localparam int SC = 4;
`ifdef SCORE_CTRL_HIGH_SCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif

    logic       clock, reset, score_in, game_over, start;
    logic [6:0] hex2, hex1, hex0;
    logic       playing, show_best, new_best, overflow;

    score_ctrl #(.SHOW_CYCLES(SC)) dut (
        .clock     (clock),
        .reset     (reset),
        .score_in  (score_in),
        .game_over (game_over),
        .start     (start),
        .hex2      (hex2),
        .hex1      (hex1),
        .hex0      (hex0),
        .playing   (playing),
        .show_best (show_best),
        .new_best  (new_best),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    // ---------------- behavioural model ----------------
    int m_mode;          // 0 idle, 1 play, 2 over
    int m_score, m_best, m_cyc, m_disp;
    bit m_ovf, m_nb, m_show;
    bit p_si, p_go, p_st;

    function automatic logic [20:0] hex_of(input int v);
        return {seg_tab[(v / 100) % 10], seg_tab[(v / 10) % 10], seg_tab[v % 10]};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_score = 0; m_best = 0; m_cyc = 0; m_disp = 0;
        m_ovf = 0; m_nb = 0; m_show = 0;
        p_si = 0; p_go = 0; p_st = 0;
    endtask

    task automatic model_edge();
        bit pt, go, st;
        pt = score_in && !p_si;
        go = game_over && !p_go;
        st = start && !p_st;
        // displays lag the score/best registers by one clock
        m_disp = m_show ? m_best : m_score;
        if (st) begin
            m_mode = 1; m_score = 0; m_ovf = 0; m_show = 0;
        end else if (m_mode == 1) begin
            if (pt) begin
                m_score = (m_score + 1) % 1000;
                if (m_score == 0) m_ovf = 1;
            end
            if (go) begin
                m_mode = 2; m_cyc = 0; m_show = 0;
                if (HS && m_score > m_best) begin
                    m_best = m_score; m_nb = 1;
                end else begin
                    m_nb = 0;
                end
            end
        end else if (m_mode == 2) begin
            m_cyc++;
            m_show = HS && (((m_cyc / SC) % 2) == 1);
        end
        p_si = score_in; p_go = game_over; p_st = start;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_score(input string name, input int v);
        cmp(name, 32'({hex2, hex1, hex0}), 32'(hex_of(v)));
    endtask

    // One clock: update model at the edge, compare all outputs 1 unit later.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        cmp("m_hex",      32'({hex2, hex1, hex0}), 32'(hex_of(m_disp)));
        cmp("m_playing",  32'(playing),   32'(m_mode == 1));
        cmp("m_show",     32'(show_best), 32'(m_show));
        cmp("m_new_best", 32'(new_best),  32'(m_nb));
        cmp("m_overflow", 32'(overflow),  32'(m_ovf));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input int hi, input int lo);
        score_in = 1'b1; ticks(hi);
        score_in = 1'b0; ticks(lo);
    endtask

    task automatic start_round();
        start = 1'b1; tick();
        start = 1'b0; tick();
    endtask

    // Reset asserted and released between two clock edges
    task automatic do_reset();
        #2 reset = 1'b1;
        model_reset();
        #2 reset = 1'b0;
    endtask

    typedef struct {
        logic si;
        logic go;
        logic st;
        int   cycles;
        int   exp_score;
        logic exp_play;
        logic exp_ovf;
    } vec_t;

    vec_t vecs [14];

    initial begin
        reset = 1'b1; score_in = 1'b0; game_over = 1'b0; start = 1'b0;
        model_reset();
        #12 reset = 1'b0;
        cmp("rst_hex",      32'({hex2, hex1, hex0}), 32'({3{7'b1000000}}));
        cmp("rst_playing",  32'(playing),   32'(0));
        cmp("rst_show",     32'(show_best), 32'(0));
        cmp("rst_new_best", 32'(new_best),  32'(0));
        cmp("rst_overflow", 32'(overflow),  32'(0));

        // ---------------- vector table ----------------
        vecs[0]  = '{1'b0, 1'b0, 1'b0,  2, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0,  2, 0, 1'b0, 1'b0};  // point in IDLE ignored
        vecs[2]  = '{1'b0, 1'b0, 1'b0,  2, 0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1,  2, 0, 1'b1, 1'b0};  // start
        vecs[4]  = '{1'b0, 1'b0, 1'b0,  2, 0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0,  2, 1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0,  2, 1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 10, 2, 1'b1, 1'b0};  // held high counts once
        vecs[8]  = '{1'b0, 1'b0, 1'b0,  2, 2, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0,  2, 3, 1'b0, 1'b0};  // point + game_over
        vecs[10] = '{1'b0, 1'b0, 1'b0,  2, 3, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0,  2, 3, 1'b0, 1'b0};  // frozen in OVER
        vecs[12] = '{1'b0, 1'b0, 1'b1,  2, 0, 1'b1, 1'b0};  // restart
        vecs[13] = '{1'b0, 1'b0, 1'b0,  2, 0, 1'b1, 1'b0};
        for (int i = 0; i < 14; i++) begin
            score_in = vecs[i].si; game_over = vecs[i].go; start = vecs[i].st;
            ticks(vecs[i].cycles);
            chk_score($sformatf("vec%0d_score", i), vecs[i].exp_score);
            cmp($sformatf("vec%0d_playing", i), 32'(playing), 32'(vecs[i].exp_play));
            cmp($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        end

        // ---------------- five 2-high/2-low pulses ----------------
        score_in = 1'b0; game_over = 1'b0; start = 1'b0;
        do_reset();
        start_round();
        repeat (5) pulse(2, 2);
        cmp("five_hex0", 32'(hex0), 32'(7'b0010010));
        cmp("five_hex1", 32'(hex1), 32'(7'b1000000));
        cmp("five_hex2", 32'(hex2), 32'(7'b1000000));
        cmp("five_playing", 32'(playing), 32'(1));

        // ---------------- 1000 points wrap ----------------
        start_round();
        repeat (1000) pulse(1, 1);
        chk_score("wrap_score", 0);
        cmp("wrap_overflow", 32'(overflow), 32'(1));
        start = 1'b1; tick();
        cmp("wrap_ovf_clr", 32'(overflow), 32'(0));
        start = 1'b0; tick();
        chk_score("wrap_restart", 0);

        // ---------------- two rounds, 12 then 7 ----------------
        do_reset();
        start_round();
        repeat (12) pulse(1, 1);
        game_over = 1'b1; tick();
        game_over = 1'b0;
        cmp("r1_new_best", 32'(new_best), 32'(HS));
        cmp("r1_playing", 32'(playing), 32'(0));
        tick();
        chk_score("r1_frozen", 12);
        start_round();
        repeat (7) pulse(1, 1);
        game_over = 1'b1; tick();
        game_over = 1'b0;
        cmp("r2_new_best", 32'(new_best), 32'(0));
        ticks(SC);
        cmp("r2_show_best", 32'(show_best), 32'(HS));
        tick();
        chk_score("r2_disp_best", HS ? 12 : 7);
        ticks(SC);
        chk_score("r2_disp_score", 7);

        // ---------------- same-cycle point + game_over at 41 ----------------
        start_round();
        repeat (41) pulse(1, 1);
        score_in = 1'b1; game_over = 1'b1; tick();
        score_in = 1'b0; game_over = 1'b0; tick();
        chk_score("pg_frozen42", 42);
        cmp("pg_new_best", 32'(new_best), 32'(HS));
        pulse(1, 1);
        ticks(SC - 1);
        chk_score("pg_best42", 42);

        // ---------------- same-cycle start + game_over in PLAY ----------------
        start_round();
        repeat (3) pulse(1, 1);
        start = 1'b1; game_over = 1'b1; tick();
        cmp("sg_playing", 32'(playing), 32'(1));
        start = 1'b0; game_over = 1'b0; tick();
        chk_score("sg_score", 0);
        cmp("sg_new_best_hold", 32'(new_best), 32'(HS));

        // ---------------- asynchronous reset in OVER ----------------
        pulse(1, 1); pulse(1, 1);
        game_over = 1'b1; tick();
        game_over = 1'b0; ticks(2);
        #2 reset = 1'b1;
        #1;
        cmp("arst_hex",      32'({hex2, hex1, hex0}), 32'({3{7'b1000000}}));
        cmp("arst_playing",  32'(playing),   32'(0));
        cmp("arst_show",     32'(show_best), 32'(0));
        cmp("arst_new_best", 32'(new_best),  32'(0));
        cmp("arst_overflow", 32'(overflow),  32'(0));
        model_reset();
        #1 reset = 1'b0;
        pulse(1, 1); pulse(1, 1);
        chk_score("arst_idle_score", 0);
        cmp("arst_idle_playing", 32'(playing), 32'(0));

        // ---------------- randomized stimulus ----------------
        for (int i = 0; i < 3000; i++) begin
            score_in  = 1'($urandom_range(0, 1));
            game_over = ($urandom_range(0, 39) == 0);
            start     = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
